pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Merges three sources into per-stage enables:
//   - load-use stall request from the hazard unit
//   - ID-stage redirect (taken branch/jump)
//   - data-memory wait handshake
//  Tracks the memory wait in a small FSM, raises a sticky timeout, and counts stall cycles for performance debug.
// PARAMETERS
//  MAX_WAIT       16  MEM_WAIT cycles before mem_timeout sets (>=1)
//  REDIRECT_BUBS  1   cycles if_id_flush is held after a redirect (1..7)
//  CNT_W          16  width of stall_cycles counter
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-high reset
//  load_use_hz   in   1      1 = load-use stall request (hazard unit active-low stall inverted)
//  redirect      in   1      1 = branch taken / jump resolved in ID this cycle
//  dmem_req      in   1      MEM stage holds a load or store
//  dmem_ready    in   1      data memory completes the access this cycle
//  pc_write      out  1      PC load enable
//  if_id_write   out  1      IF/ID register enable
//  if_id_flush   out  1      IF/ID clears to NOP at this edge
//  id_ex_bubble  out  1      ID/EX control fields zeroed at this edge
//  ex_mem_write  out  1      EX/MEM register enable
//  mem_wb_write  out  1      MEM/WB register enable
//  mem_timeout   out  1      sticky: wait exceeded MAX_WAIT
//  stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
// BEHAVIOUR
//  FSM states: RUN, FLUSH, WAIT. ret_flush (1b) and bub_cnt (3b) record the FLUSH context; wait_cnt counts WAIT cycles.
//  Outputs are Mealy: combinational from state + inputs, same-cycle (0 latency).
//  Reset (rst=1, async):
//   - state=RUN, counters=0, mem_timeout=0, stall_cycles=0
//   - while rst=1: pc_write, if_id_write, ex_mem_write, mem_wb_write = 0; id_ex_bubble=1; if_id_flush=0
//  Default (no condition active): all *_write=1, flush=0, bubble=0.
//  Priority each cycle: freeze > load-use > redirect.
//  freeze = (state==WAIT & !dmem_ready) | (state!=WAIT & dmem_req & !dmem_ready):
//   - all four *_write=0, bubble=0, flush=0; pipeline fully held, so pending requests stay asserted
//   - RUN/FLUSH -> WAIT on freeze; ret_flush := (state==FLUSH); bub_cnt holds
//  WAIT & dmem_ready -> outputs default this cycle; next state FLUSH if ret_flush, else RUN; wait_cnt := 0.
//  wait_cnt increments each WAIT cycle; wait_cnt==MAX_WAIT-1 while still waiting -> mem_timeout:=1.
//   - mem_timeout clears only on rst; WAIT continues, it never aborts.
//  RUN, no freeze, load_use_hz=1:
//   - pc_write=0, if_id_write=0, id_ex_bubble=1; EX/MEM, MEM/WB keep writing
//   - redirect ignored this cycle (branch operands stale)
//   - stays RUN
//  RUN, no freeze, !load_use_hz, redirect=1:
//   - if_id_flush=1, pc_write=1
//   - REDIRECT_BUBS==1 -> stay RUN; else -> FLUSH, bub_cnt := REDIRECT_BUBS-1
//  FLUSH, no freeze:
//   - if_id_flush=1; load_use_hz and redirect ignored (ID holds a bubble)
//   - bub_cnt decrements; at bub_cnt==1 -> RUN
//  stall_cycles += 1 on each clk edge where pc_write==0 and rst==0; saturates at all-ones.
//  dmem_req=0 with dmem_ready=1 is harmless (ignored outside WAIT).
//  rst mid-WAIT/FLUSH: immediate return to RUN, no partial flush retained.
// TESTING
//  1 rst=1 -> pc_write=0, id_ex_bubble=1, stall_cycles=0; release -> default enables next cycle.
//  2 load_use_hz=1 one cycle in RUN -> pc_write=if_id_write=0, id_ex_bubble=1, ex_mem_write=1; stall_cycles=1.
//  3 dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> all writes 0 for 3 cycles, 1 on the 4th; stall_cycles=3.
//  4 MAX_WAIT=4, ready withheld 6 cycles -> mem_timeout=1 after the 4th wait cycle, sticky after ready.
//  5 REDIRECT_BUBS=3, redirect=1 -> if_id_flush=1 for 3 cycles; a freeze in cycle 2 holds flush, resumes after ready.
//  6 load_use_hz=1 & redirect=1 together -> stall wins, if_id_flush=0; redirect next cycle -> flush=1.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline stall controller and the pipeline stages.
// The master drives the hazard/memory requests; the slave (controller) drives the stage enables.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             load_use_hz;
  logic             redirect;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output load_use_hz, redirect, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
    input  ex_mem_write, mem_wb_write, mem_timeout, stall_cycles
  );

  modport slave (
    input  load_use_hz, redirect, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
    output ex_mem_write, mem_wb_write, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, ID redirect and
// data-memory wait into per-stage enables (Mealy), with sticky timeout and stall counter.
module pipeline_stall_ctrl #(
  parameter int unsigned MAX_WAIT      = 16,
  parameter int unsigned REDIRECT_BUBS = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stall_ctrl_if.slave  bus
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned BUB_W  = 3;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]        r_state;
  logic              r_ret_flush;
  logic [BUB_W-1:0]  r_bub_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic [1:0]        w_state_nxt;
  logic              w_ret_flush_nxt;
  logic [BUB_W-1:0]  w_bub_cnt_nxt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              w_mem_timeout_nxt;
  logic [CNT_W-1:0]  w_stall_cycles_nxt;

  logic w_freeze;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_ex_mem_write;
  logic w_mem_wb_write;

  // State and context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_ret_flush    <= 1'b0;
      r_bub_cnt      <= '0;
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ret_flush    <= w_ret_flush_nxt;
      r_bub_cnt      <= w_bub_cnt_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_mem_timeout  <= w_mem_timeout_nxt;
      r_stall_cycles <= w_stall_cycles_nxt;
    end
  end

  // Next-state and same-cycle stage enables; priority freeze > load-use > redirect
  always_comb begin
    w_state_nxt        = r_state;
    w_ret_flush_nxt    = r_ret_flush;
    w_bub_cnt_nxt      = r_bub_cnt;
    w_wait_cnt_nxt     = r_wait_cnt;
    w_mem_timeout_nxt  = r_mem_timeout;
    w_stall_cycles_nxt = r_stall_cycles;
    w_pc_write         = 1'b1;
    w_if_id_write      = 1'b1;
    w_if_id_flush      = 1'b0;
    w_id_ex_bubble     = 1'b0;
    w_ex_mem_write     = 1'b1;
    w_mem_wb_write     = 1'b1;

    w_freeze = (r_state == ST_WAIT) ? !bus.dmem_ready
                                    : (bus.dmem_req && !bus.dmem_ready);

    if (w_freeze) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_ex_mem_write = 1'b0;
      w_mem_wb_write = 1'b0;
      if (r_state != ST_WAIT) begin
        w_state_nxt     = ST_WAIT;
        w_ret_flush_nxt = (r_state == ST_FLUSH);
      end else if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
        w_mem_timeout_nxt = 1'b1;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
      end
    end else begin
      case (r_state)
        ST_WAIT: begin
          w_state_nxt    = r_ret_flush ? ST_FLUSH : ST_RUN;
          w_wait_cnt_nxt = '0;
        end
        ST_FLUSH: begin
          w_if_id_flush = 1'b1;
          w_bub_cnt_nxt = r_bub_cnt - BUB_W'(1);
          if (r_bub_cnt == BUB_W'(1)) w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
          if (bus.load_use_hz) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
          end else if (bus.redirect) begin
            w_if_id_flush = 1'b1;
            if (REDIRECT_BUBS > 1) begin
              w_state_nxt   = ST_FLUSH;
              w_bub_cnt_nxt = BUB_W'(REDIRECT_BUBS - 1);
            end
          end
        end
      endcase
    end

    if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
      w_stall_cycles_nxt = r_stall_cycles + CNT_W'(1);

    // Hold every stage and bubble ID/EX for as long as reset is asserted
    if (rst) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_bubble = 1'b1;
      w_ex_mem_write = 1'b0;
      w_mem_wb_write = 1'b0;
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.ex_mem_write = w_ex_mem_write;
  assign bus.mem_wb_write = w_mem_wb_write;
  assign bus.mem_timeout  = r_mem_timeout;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench for pipeline_stall_ctrl: stimulus queues expected enables,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_stall_ctrl;

  localparam int unsigned CNT_W = 4;

  typedef struct {
    string       name;
    logic [10:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vec_vld = 1'b0;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .MAX_WAIT      (4),
    .REDIRECT_BUBS (3),
    .CNT_W         (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected word: {pc, if_id_w, flush, bubble, ex_mem_w, mem_wb_w, timeout, stall_cycles}
  function automatic logic [10:0] e(input bit pc, input bit ifw, input bit fl, input bit bub,
                                    input bit exw, input bit wbw, input bit tmo,
                                    input logic [3:0] cnt);
    return {pc, ifw, fl, bub, exw, wbw, tmo, cnt};
  endfunction

  task automatic vec(input string name, input bit r, input bit lu, input bit rd,
                     input bit rq, input bit rdy, input logic [10:0] exp_v);
    exp_t x;
    @(posedge clk);
    #1;
    rst             = r;
    bus.load_use_hz = lu;
    bus.redirect    = rd;
    bus.dmem_req    = rq;
    bus.dmem_ready  = rdy;
    x.name = name;
    x.v    = exp_v;
    sb_q.push_back(x);
    vec_vld = 1'b1;
  endtask

  // Monitor: one output word per driven cycle
  always @(negedge clk) begin
    if (vec_vld) begin
      logic [10:0] act;
      exp_t        x;
      act = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
             bus.ex_mem_write, bus.mem_wb_write, bus.mem_timeout, bus.stall_cycles};
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got %b required an expected entry", act);
      end else begin
        x = sb_q.pop_front();
        if (act !== x.v) begin
          n_fail++;
          $display("FAIL %s: got %b required %b", x.name, act, x.v);
        end
      end
    end
  end

  initial begin
    bus.load_use_hz = 1'b0;
    bus.redirect    = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_ready  = 1'b0;

    //   name            rst lu rd rq rdy  pc if fl bb ex wb to cnt
    vec("reset",          1, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    vec("release",        0, 0, 0, 0, 0, e(1, 1, 0, 0, 1, 1, 0, 0));
    vec("load_use",       0, 1, 0, 0, 0, e(0, 0, 0, 1, 1, 1, 0, 0));
    vec("after_lu",       0, 0, 0, 0, 0, e(1, 1, 0, 0, 1, 1, 0, 1));
    vec("freeze_run",     0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 1));
    vec("wait_1",         0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 2));
    vec("wait_2",         0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 3));
    vec("wait_ready",     0, 0, 0, 1, 1, e(1, 1, 0, 0, 1, 1, 0, 4));
    vec("run_req_ready",  0, 0, 0, 1, 1, e(1, 1, 0, 0, 1, 1, 0, 4));
    vec("stray_ready",    0, 0, 0, 0, 1, e(1, 1, 0, 0, 1, 1, 0, 4));
    vec("lu_beats_redir", 0, 1, 1, 0, 0, e(0, 0, 0, 1, 1, 1, 0, 4));
    vec("redirect",       0, 0, 1, 0, 0, e(1, 1, 1, 0, 1, 1, 0, 5));
    vec("flush_2_lu_ign", 0, 1, 0, 0, 0, e(1, 1, 1, 0, 1, 1, 0, 5));
    vec("flush_3",        0, 0, 0, 0, 0, e(1, 1, 1, 0, 1, 1, 0, 5));
    vec("flush_done",     0, 0, 0, 0, 0, e(1, 1, 0, 0, 1, 1, 0, 5));
    vec("redirect_b",     0, 0, 1, 0, 0, e(1, 1, 1, 0, 1, 1, 0, 5));
    vec("freeze_flush",   0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 5));
    vec("flush_wait",     0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 6));
    vec("flush_wait_rdy", 0, 0, 0, 1, 1, e(1, 1, 0, 0, 1, 1, 0, 7));
    vec("flush_resume_2", 0, 0, 0, 0, 0, e(1, 1, 1, 0, 1, 1, 0, 7));
    vec("flush_resume_3", 0, 0, 0, 0, 0, e(1, 1, 1, 0, 1, 1, 0, 7));
    vec("flush_b_done",   0, 0, 0, 0, 0, e(1, 1, 0, 0, 1, 1, 0, 7));
    vec("to_freeze",      0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 7));
    vec("to_wait_1",      0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 8));
    vec("to_wait_2",      0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 9));
    vec("to_wait_3",      0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 10));
    vec("to_wait_4",      0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 11));
    vec("to_wait_5_tmo",  0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 1, 12));
    vec("to_ready",       0, 0, 0, 1, 1, e(1, 1, 0, 0, 1, 1, 1, 13));
    vec("tmo_sticky",     0, 0, 0, 0, 0, e(1, 1, 0, 0, 1, 1, 1, 13));
    vec("sat_lu_1",       0, 1, 0, 0, 0, e(0, 0, 0, 1, 1, 1, 1, 13));
    vec("sat_lu_2",       0, 1, 0, 0, 0, e(0, 0, 0, 1, 1, 1, 1, 14));
    vec("sat_lu_3",       0, 1, 0, 0, 0, e(0, 0, 0, 1, 1, 1, 1, 15));
    vec("sat_hold",       0, 0, 0, 0, 0, e(1, 1, 0, 0, 1, 1, 1, 15));
    vec("redirect_c",     0, 0, 1, 0, 0, e(1, 1, 1, 0, 1, 1, 1, 15));
    vec("rst_mid_flush",  1, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    vec("rst_release",    0, 0, 0, 0, 0, e(1, 1, 0, 0, 1, 1, 0, 0));

    @(negedge clk);
    #1;
    vec_vld = 1'b0;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
